// File: rtl/mac_table_arbiter_if.sv
// Request, MAC_table access and response bundle around mac_table_arbiter.
// The arbiter takes the slave modport; ingress parsers plus MAC_table form the master side.
interface mac_table_arbiter_if #(
  parameter int pPORT_NUM = 4,
  parameter int pSLOTS    = 1024
);
  localparam int SW = $clog2(pSLOTS);
  localparam int PW = $clog2(pPORT_NUM);

  logic [pPORT_NUM-1:0]    i_req_valid;
  logic [pPORT_NUM-1:0]    o_req_ready;
  logic [pPORT_NUM*SW-1:0] i_req_sa;
  logic [pPORT_NUM*SW-1:0] i_req_da;
  logic                    o_tbl_we;
  logic [PW-1:0]           o_tbl_port_num;
  logic [SW-1:0]           o_tbl_mac_sa;
  logic [SW-1:0]           o_tbl_mac_da;
  logic [PW-1:0]           i_tbl_port_num;
  logic [pPORT_NUM-1:0]    o_rsp_valid;
  logic [PW-1:0]           o_rsp_port;
  logic                    o_rsp_flood;

  modport slave (
    input  i_req_valid, i_req_sa, i_req_da, i_tbl_port_num,
    output o_req_ready, o_tbl_we, o_tbl_port_num, o_tbl_mac_sa, o_tbl_mac_da,
           o_rsp_valid, o_rsp_port, o_rsp_flood
  );

  modport master (
    output i_req_valid, i_req_sa, i_req_da, i_tbl_port_num,
    input  o_req_ready, o_tbl_we, o_tbl_port_num, o_tbl_mac_sa, o_tbl_mac_da,
           o_rsp_valid, o_rsp_port, o_rsp_flood
  );
endinterface

// File: rtl/mac_table_arbiter.sv
// Round-robin arbiter sharing one MAC_table learn/lookup slot among pPORT_NUM ingress ports.
// Optional MAC_ARB_BCAST_FLOOD_EN: lookups of slot pSLOTS-1 answer as flood instead of table data.
module mac_table_arbiter #(
  parameter int pPORT_NUM = 4,
  parameter int pSLOTS    = 1024
) (
  input logic                iclk,
  input logic                i_rst_n,
  mac_table_arbiter_if.slave bus
);
  localparam int SW = $clog2(pSLOTS);
  localparam int PW = $clog2(pPORT_NUM);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_reg, state_next;
  logic [PW-1:0]        ptr_reg, ptr_next;
  logic [PW-1:0]        port_reg;
  logic [SW-1:0]        sa_reg;
  logic [SW-1:0]        da_reg;
  logic [PW-1:0]        rsp_port_reg;
  logic [pPORT_NUM-1:0] grant;
  logic [pPORT_NUM-1:0] rsp_vec;
  logic                 found;
  logic [PW-1:0]        win;

  logic [SW-1:0]        sa_arr   [pPORT_NUM];
  logic [SW-1:0]        da_arr   [pPORT_NUM];
  logic [PW-1:0]        cand_idx [pPORT_NUM];
  logic [pPORT_NUM-1:0] cand_valid;

  // Candidate gi is the port gi positions after the RR pointer, wrapping at pPORT_NUM.
  for (genvar gi = 0; gi < pPORT_NUM; gi++) begin : g_port
    logic [PW:0] sum;
    assign sa_arr[gi]     = bus.i_req_sa[gi*SW +: SW];
    assign da_arr[gi]     = bus.i_req_da[gi*SW +: SW];
    assign sum            = {1'b0, ptr_reg} + (PW+1)'(gi);
    assign cand_idx[gi]   = (sum >= (PW+1)'(pPORT_NUM)) ? PW'(sum - (PW+1)'(pPORT_NUM))
                                                          : PW'(sum);
    assign cand_valid[gi] = bus.i_req_valid[cand_idx[gi]];
  end

  // Scan from the far end so the candidate closest to the pointer overrides the rest.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = pPORT_NUM - 1; i >= 0; i--) begin
      if (cand_valid[i]) begin
        found = 1'b1;
        win   = cand_idx[i];
      end
    end
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant      = '0;
    unique case (state_reg)
      IDLE: begin
        if (found) begin
          grant[win] = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ptr_next   = (port_reg == PW'(pPORT_NUM - 1)) ? '0 : port_reg + PW'(1);
        state_next = WAIT;
      end
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rsp_vec = '0;
    if (state_reg == RESP) rsp_vec[port_reg] = 1'b1;
  end

`ifdef MAC_ARB_BCAST_FLOOD_EN
  localparam logic [SW-1:0] BCAST_SLOT = SW'(pSLOTS - 1);
  logic rsp_flood_reg;
`endif

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      port_reg      <= '0;
      sa_reg        <= '0;
      da_reg        <= '0;
      rsp_port_reg  <= '0;
`ifdef MAC_ARB_BCAST_FLOOD_EN
      rsp_flood_reg <= 1'b0;
`endif
    end else begin
      if (state_reg == IDLE && found) begin
        port_reg <= win;
        sa_reg   <= sa_arr[win];
        da_reg   <= da_arr[win];
      end
      // Table read data registered on the ISSUE edge is valid during WAIT.
      if (state_reg == WAIT) begin
`ifdef MAC_ARB_BCAST_FLOOD_EN
        if (da_reg == BCAST_SLOT) begin
          rsp_port_reg  <= '0;
          rsp_flood_reg <= 1'b1;
        end else begin
          rsp_port_reg  <= bus.i_tbl_port_num;
          rsp_flood_reg <= 1'b0;
        end
`else
        rsp_port_reg <= bus.i_tbl_port_num;
`endif
      end
    end
  end

  // Ready is combinational in IDLE, so it is also gated while reset is held.
  assign bus.o_req_ready    = grant & {pPORT_NUM{i_rst_n}};
  assign bus.o_tbl_we       = (state_reg == ISSUE);
  assign bus.o_tbl_port_num = port_reg;
  assign bus.o_tbl_mac_sa   = sa_reg;
  assign bus.o_tbl_mac_da   = da_reg;
  assign bus.o_rsp_valid    = rsp_vec;
  assign bus.o_rsp_port     = rsp_port_reg;
`ifdef MAC_ARB_BCAST_FLOOD_EN
  assign bus.o_rsp_flood    = rsp_flood_reg;
`else
  assign bus.o_rsp_flood    = 1'b0;
`endif

endmodule

// File: tb/tb_mac_table_arbiter.sv
// Self-checking bench for mac_table_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model (RR order, 4-cycle service, read-before-write table).
module tb_mac_table_arbiter;
  localparam int N     = 4;
  localparam int SLOTS = 1024;
  localparam int SW    = 10;
  localparam int PW    = 2;

  logic iclk = 1'b0;
  logic i_rst_n = 1'b1;
  always #5 iclk = ~iclk;

  mac_table_arbiter_if #(.pPORT_NUM(N), .pSLOTS(SLOTS)) bus ();
  mac_table_arbiter #(.pPORT_NUM(N), .pSLOTS(SLOTS)) dut (
    .iclk    (iclk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // MAC_table stand-in: registered read, write in the same cycle lands after the read.
  bit   [PW-1:0] tbl_mem [SLOTS];
  logic          pre_we = 1'b0;
  logic [SW-1:0] pre_addr = '0;
  logic [PW-1:0] pre_data = '0;
  always @(posedge iclk) begin
    if (pre_we) tbl_mem[pre_addr] <= pre_data;
    else if (bus.o_tbl_we) tbl_mem[bus.o_tbl_mac_sa] <= bus.o_tbl_port_num;
    bus.i_tbl_port_num <= tbl_mem[bus.o_tbl_mac_da];
  end

  // Reference model state.
  int ref_tbl [SLOTS];
  int ref_ptr = 0;
  int n_chk = 0;
  int n_pass = 0;
  int grant_q[$];
  int grant_t[$];

  typedef struct {
    logic [N-1:0]  rdy;
    logic          we1;
    logic [SW-1:0] sa1;
    logic [SW-1:0] da1;
    logic [PW-1:0] pn1;
    logic          we2;
    logic [N-1:0]  rv2;
    logic [N-1:0]  rv3;
    logic [PW-1:0] rp3;
    logic          rf3;
    logic [N-1:0]  rv4;
    int            exp_port;
    bit            exp_flood;
  } obs_t;

  function automatic bit is_flood(int da);
`ifdef MAC_ARB_BCAST_FLOOD_EN
    return da == SLOTS - 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge iclk);
    i_rst_n = 1'b0;
    bus.i_req_valid = '0;
    repeat (2) @(negedge iclk);
    i_rst_n = 1'b1;
    ref_ptr = 0;
  endtask

  task automatic preload(input int addr, input int data);
    @(negedge iclk);
    pre_we = 1'b1; pre_addr = SW'(addr); pre_data = PW'(data);
    @(negedge iclk);
    pre_we = 1'b0;
    ref_tbl[addr] = data;
  endtask

  // Drives one request from a single port and records what the DUT shows at T..T+4.
  task automatic send(input int p, input int sa, input int da, output obs_t o);
    int waited;
    waited = 0;
    o = '{default: 0};
    bus.i_req_sa[p*SW +: SW] = SW'(sa);
    bus.i_req_da[p*SW +: SW] = SW'(da);
    bus.i_req_valid = '0;
    bus.i_req_valid[p] = 1'b1;
    #1;
    while (bus.o_req_ready == '0 && waited < 8) begin
      @(negedge iclk); #1; waited++;
    end
    o.rdy = bus.o_req_ready;
    @(negedge iclk);
    bus.i_req_valid = '0;
    #1;
    o.we1 = bus.o_tbl_we; o.sa1 = bus.o_tbl_mac_sa; o.da1 = bus.o_tbl_mac_da; o.pn1 = bus.o_tbl_port_num;
    @(negedge iclk); #1;
    o.we2 = bus.o_tbl_we; o.rv2 = bus.o_rsp_valid;
    @(negedge iclk); #1;
    o.rv3 = bus.o_rsp_valid; o.rp3 = bus.o_rsp_port; o.rf3 = bus.o_rsp_flood;
    @(negedge iclk); #1;
    o.rv4 = bus.o_rsp_valid;
    if (o.rdy != '0) begin
      o.exp_flood = is_flood(da);
      o.exp_port  = o.exp_flood ? 0 : ref_tbl[da];
      ref_tbl[sa] = p;
      ref_ptr     = (p + 1) % N;
    end
    $display("txn port=%0d sa=%0d da=%0d ready=%b rsp_valid=%b rsp_port=%0d flood=%0d",
             p, sa, da, o.rdy, o.rv3, o.rp3, o.rf3);
  endtask

  // Cycle-by-cycle traffic against the model; all_valid keeps every port requesting.
  task automatic run_traffic(input int cycles, input bit all_valid);
    bit           pend [N];
    int           psa [N];
    int           pda [N];
    int           busy_until, last_t, last_p, last_sa, last_da, last_port, q;
    bit           last_flood;
    logic [N-1:0] exp_rdy, exp_rv;
    busy_until = 0; last_t = -100; last_p = 0; last_sa = 0; last_da = 0; last_port = 0;
    last_flood = 1'b0;
    for (int p = 0; p < N; p++) begin pend[p] = 1'b0; psa[p] = 0; pda[p] = 0; end
    grant_q.delete(); grant_t.delete();
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pend[p] && (all_valid || $urandom_range(0, 2) == 0)) begin
          pend[p] = 1'b1;
          psa[p]  = $urandom_range(0, SLOTS - 1);
          pda[p]  = ($urandom_range(0, 7) == 0) ? SLOTS - 1 : $urandom_range(0, SLOTS - 1);
        end
        bus.i_req_valid[p] = pend[p];
        bus.i_req_sa[p*SW +: SW] = SW'(psa[p]);
        bus.i_req_da[p*SW +: SW] = SW'(pda[p]);
      end
      #1;
      exp_rdy = '0;
      if (c >= busy_until) begin
        for (int k = N - 1; k >= 0; k--) begin
          q = (ref_ptr + k) % N;
          if (pend[q]) begin exp_rdy = '0; exp_rdy[q] = 1'b1; end
        end
      end
      n_chk++;
      if (bus.o_req_ready !== exp_rdy)
        $display("FAIL traffic_ready cyc=%0d got=%b exp=%b", c, bus.o_req_ready, exp_rdy);
      else n_pass++;
      n_chk++;
      if (bus.o_tbl_we !== (c == last_t + 1))
        $display("FAIL traffic_we cyc=%0d got=%b exp=%b", c, bus.o_tbl_we, (c == last_t + 1));
      else n_pass++;
      if (c == last_t + 1) begin
        n_chk++;
        if (bus.o_tbl_mac_sa !== SW'(last_sa) || bus.o_tbl_mac_da !== SW'(last_da) ||
            bus.o_tbl_port_num !== PW'(last_p))
          $display("FAIL traffic_tbl cyc=%0d got sa=%0d da=%0d pn=%0d exp sa=%0d da=%0d pn=%0d", c,
                   bus.o_tbl_mac_sa, bus.o_tbl_mac_da, bus.o_tbl_port_num, last_sa, last_da, last_p);
        else n_pass++;
      end
      exp_rv = '0;
      if (c == last_t + 3) exp_rv[last_p] = 1'b1;
      n_chk++;
      if (bus.o_rsp_valid !== exp_rv)
        $display("FAIL traffic_rsp_valid cyc=%0d got=%b exp=%b", c, bus.o_rsp_valid, exp_rv);
      else n_pass++;
      if (c == last_t + 3) begin
        n_chk++;
        if (bus.o_rsp_port !== PW'(last_port) || bus.o_rsp_flood !== last_flood)
          $display("FAIL traffic_rsp cyc=%0d got port=%0d flood=%0d exp port=%0d flood=%0d", c,
                   bus.o_rsp_port, bus.o_rsp_flood, last_port, last_flood);
        else n_pass++;
      end
      if (exp_rdy != '0) begin
        for (int p = 0; p < N; p++) if (exp_rdy[p]) last_p = p;
        last_t = c; last_sa = psa[last_p]; last_da = pda[last_p];
        last_flood = is_flood(last_da);
        last_port  = last_flood ? 0 : ref_tbl[last_da];
        ref_tbl[last_sa] = last_p;
        ref_ptr = (last_p + 1) % N;
        busy_until = c + 4;
        pend[last_p] = 1'b0;
        grant_q.push_back(last_p);
        grant_t.push_back(c);
        $display("txn cyc=%0d port=%0d sa=%0d da=%0d exp_port=%0d flood=%0d",
                 c, last_p, last_sa, last_da, last_port, last_flood);
      end
      @(negedge iclk);
    end
    bus.i_req_valid = '0;
    repeat (4) @(negedge iclk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1;
    bus.i_req_valid = '0; bus.i_req_sa = '0; bus.i_req_da = '0;
    #2 i_rst_n = 1'b0;
    bus.i_req_valid = '1;
    #1;
    n_chk++;
    if (bus.o_req_ready !== '0 || bus.o_tbl_we !== 1'b0 || bus.o_rsp_valid !== '0)
      $display("FAIL reset_strobes got ready=%b we=%b rsp_valid=%b exp all 0",
               bus.o_req_ready, bus.o_tbl_we, bus.o_rsp_valid);
    else n_pass++;
    n_chk++;
    if (bus.o_tbl_port_num !== '0 || bus.o_tbl_mac_sa !== '0 || bus.o_tbl_mac_da !== '0 ||
        bus.o_rsp_port !== '0 || bus.o_rsp_flood !== 1'b0)
      $display("FAIL reset_values got pn=%0d sa=%0d da=%0d rsp_port=%0d flood=%0d exp all 0",
               bus.o_tbl_port_num, bus.o_tbl_mac_sa, bus.o_tbl_mac_da, bus.o_rsp_port, bus.o_rsp_flood);
    else n_pass++;
    bus.i_req_valid = '0;
    preload(9, 3);
    preload(1023, 2);
    do_reset();
    #1;
    n_chk++;
    if (bus.o_req_ready !== '0)
      $display("FAIL reset_idle_ready got=%b exp=0000", bus.o_req_ready);
    else n_pass++;
    @(negedge iclk);
  endtask

  task automatic test_single();
    obs_t o;
    send(2, 5, 9, o);
    n_chk++;
    if (o.rdy !== 4'b0100) $display("FAIL single_ready got=%b exp=0100", o.rdy); else n_pass++;
    n_chk++;
    if (o.we1 !== 1'b1 || o.sa1 !== 10'd5 || o.da1 !== 10'd9 || o.pn1 !== 2'd2)
      $display("FAIL single_issue got we=%b sa=%0d da=%0d pn=%0d exp we=1 sa=5 da=9 pn=2",
               o.we1, o.sa1, o.da1, o.pn1);
    else n_pass++;
    n_chk++;
    if (o.we2 !== 1'b0 || o.rv2 !== '0)
      $display("FAIL single_wait got we=%b rsp_valid=%b exp we=0 rsp_valid=0000", o.we2, o.rv2);
    else n_pass++;
    n_chk++;
    if (o.rv3 !== 4'b0100 || o.rp3 !== 2'd3 || o.rf3 !== 1'b0)
      $display("FAIL single_rsp got valid=%b port=%0d flood=%0d exp valid=0100 port=3 flood=0",
               o.rv3, o.rp3, o.rf3);
    else n_pass++;
    n_chk++;
    if (o.rv4 !== '0) $display("FAIL single_rsp_len got=%b exp=0000", o.rv4); else n_pass++;
  endtask

  task automatic test_learn_lookup();
    obs_t o;
    send(1, 7, 100, o);
    send(0, 200, 7, o);
    n_chk++;
    if (o.rv3 !== 4'b0001 || o.rp3 !== 2'd1)
      $display("FAIL learn_lookup got valid=%b port=%0d exp valid=0001 port=1", o.rv3, o.rp3);
    else n_pass++;
  endtask

  task automatic test_same_slot();
    obs_t o;
    send(0, 12, 300, o);
    send(3, 12, 12, o);
    n_chk++;
    if (o.rv3 !== 4'b1000 || o.rp3 !== 2'd0)
      $display("FAIL same_slot_rbw got valid=%b port=%0d exp valid=1000 port=0", o.rv3, o.rp3);
    else n_pass++;
    send(2, 400, 12, o);
    n_chk++;
    if (o.rv3 !== 4'b0100 || o.rp3 !== 2'd3)
      $display("FAIL same_slot_after got valid=%b port=%0d exp valid=0100 port=3", o.rv3, o.rp3);
    else n_pass++;
  endtask

  task automatic test_flood();
    obs_t o;
    send(1, 4, 1023, o);
    n_chk++;
    if (o.we1 !== 1'b1 || o.sa1 !== 10'd4 || o.pn1 !== 2'd1)
      $display("FAIL flood_learn got we=%b sa=%0d pn=%0d exp we=1 sa=4 pn=1", o.we1, o.sa1, o.pn1);
    else n_pass++;
`ifdef MAC_ARB_BCAST_FLOOD_EN
    n_chk++;
    if (o.rv3 !== 4'b0010 || o.rf3 !== 1'b1 || o.rp3 !== 2'd0)
      $display("FAIL flood_rsp got valid=%b flood=%0d port=%0d exp valid=0010 flood=1 port=0",
               o.rv3, o.rf3, o.rp3);
    else n_pass++;
`else
    n_chk++;
    if (o.rv3 !== 4'b0010 || o.rf3 !== 1'b0 || o.rp3 !== 2'd2)
      $display("FAIL flood_rsp got valid=%b flood=%0d port=%0d exp valid=0010 flood=0 port=2",
               o.rv3, o.rf3, o.rp3);
    else n_pass++;
`endif
  endtask

  task automatic test_round_robin();
    int lim;
    do_reset();
    run_traffic(21, 1'b1);
    n_chk++;
    if (grant_q.size() < 5) $display("FAIL rr_count got=%0d exp>=5", grant_q.size()); else n_pass++;
    lim = (grant_q.size() < 5) ? grant_q.size() : 5;
    for (int i = 0; i < lim; i++) begin
      n_chk++;
      if (grant_q[i] !== i % N || grant_t[i] !== 4 * i)
        $display("FAIL rr_order idx=%0d got port=%0d cyc=%0d exp port=%0d cyc=%0d",
                 i, grant_q[i], grant_t[i], i % N, 4 * i);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int exp_port;
    bus.i_req_sa[2*SW +: SW] = 10'd50;
    bus.i_req_da[2*SW +: SW] = 10'd60;
    bus.i_req_valid = 4'b0100;
    #1;
    n_chk++;
    if (bus.o_req_ready !== 4'b0100) $display("FAIL mid_ready got=%b exp=0100", bus.o_req_ready);
    else n_pass++;
    @(negedge iclk);
    bus.i_req_valid = '0;
    ref_tbl[50] = 2;
    @(negedge iclk);
    #2 i_rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.o_tbl_we !== 1'b0 || bus.o_rsp_valid !== '0 || bus.o_tbl_mac_sa !== '0 ||
        bus.o_tbl_port_num !== '0)
      $display("FAIL mid_reset_outputs got we=%b rsp_valid=%b sa=%0d pn=%0d exp all 0",
               bus.o_tbl_we, bus.o_rsp_valid, bus.o_tbl_mac_sa, bus.o_tbl_port_num);
    else n_pass++;
    @(negedge iclk);
    #2 i_rst_n = 1'b1;
    ref_ptr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge iclk); #1;
      n_chk++;
      if ({bus.o_req_ready, bus.o_tbl_we, bus.o_rsp_valid} !== '0)
        $display("FAIL mid_quiet cyc=%0d got ready=%b we=%b rsp_valid=%b exp all 0",
                 i, bus.o_req_ready, bus.o_tbl_we, bus.o_rsp_valid);
      else n_pass++;
    end
    @(negedge iclk);
    bus.i_req_sa[1*SW +: SW] = 10'd70; bus.i_req_da[1*SW +: SW] = 10'd50;
    bus.i_req_sa[3*SW +: SW] = 10'd80; bus.i_req_da[3*SW +: SW] = 10'd90;
    bus.i_req_valid = 4'b1010;
    #1;
    n_chk++;
    if (bus.o_req_ready !== 4'b0010) $display("FAIL mid_ptr_restart got=%b exp=0010", bus.o_req_ready);
    else n_pass++;
    exp_port = ref_tbl[50];
    ref_tbl[70] = 1;
    ref_ptr = 2;
    @(negedge iclk);
    bus.i_req_valid = '0;
    repeat (2) @(negedge iclk);
    #1;
    n_chk++;
    if (bus.o_rsp_valid !== 4'b0010 || bus.o_rsp_port !== PW'(exp_port))
      $display("FAIL mid_after_rsp got valid=%b port=%0d exp valid=0010 port=%0d",
               bus.o_rsp_valid, bus.o_rsp_port, exp_port);
    else n_pass++;
    $display("txn post-reset port=1 sa=70 da=50 rsp_port=%0d", bus.o_rsp_port);
    @(negedge iclk);
  endtask

  task automatic test_random();
    run_traffic(400, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_learn_lookup();
    test_same_slot();
    test_flood();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
